// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding, limits and port-slice helpers for regfile_multiport.
package regfile_pkg;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

    localparam int MAX_READ = 4;

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port with zero-register and optional write-through mux.
// REGFILE_BYPASS_EN selects write-through on a same-edge write/read hit.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ready_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              hit_zero, bypass;

    assign hit_zero = (ZERO_REG != 0) && (addr_i == '0);

`ifdef REGFILE_BYPASS_EN
    assign bypass = we_i && (waddr_i == addr_i);
`else
    logic unused_ok;
    assign bypass    = 1'b0;
    assign unused_ok = ^{we_i, waddr_i, wdata_i};
`endif

    always_comb begin
        valid_d = en_i && ready_i;
        data_d  = valid_d ? (hit_zero ? '0 : bypass ? wdata_i : mem_data_i) : data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: N-read/1-write register file with clear sequencer and hardwired-zero entry.
// Define REGFILE_BYPASS_EN for write-through on same-edge write/read to one address.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_READ*ADDR_W-1:0] ReadRegister,
    input  logic [NUM_READ-1:0]        ReadEnable,
    input  logic [ADDR_W-1:0]          WriteRegister,
    input  logic [DATA_W-1:0]          WriteData,
    input  logic                       RegWrite,
    output logic [NUM_READ*DATA_W-1:0] ReadData,
    output logic [NUM_READ-1:0]        ReadValid,
    output logic                       Ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              ready_q, ready_d;
    logic              we;

    assign we = RegWrite && ready_q && !((ZERO_REG != 0) && (WriteRegister == '0));

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        if (state_q == RF_CLEAR) begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            if (clr_idx_q == '1) begin
                state_d = RF_READY;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    // The reset edge itself leaves memory untouched; clearing starts on the first released edge.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state_q == RF_CLEAR)
                mem_q[clr_idx_q] <= '0;
            else if (we)
                mem_q[WriteRegister] <= WriteData;
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        regfile_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .clk_i     (Clk),
            .rst_i     (Reset),
            .ready_i   (ready_q),
            .en_i      (ReadEnable[g]),
            .addr_i    (ReadRegister[slice_lo(g, ADDR_W) +: ADDR_W]),
            .mem_data_i(mem_q[ReadRegister[slice_lo(g, ADDR_W) +: ADDR_W]]),
            .we_i      (we),
            .waddr_i   (WriteRegister),
            .wdata_i   (WriteData),
            .data_o    (ReadData[slice_lo(g, DATA_W) +: DATA_W]),
            .valid_o   (ReadValid[g])
        );
    end

    assign Ready = ready_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: scoreboard bench; stimulus queues expected read data, a monitor pops on ReadValid.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_reg;
    logic [1:0]  rd_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        reg_write;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic        ready;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1)) dut (
        .Clk          (clk),
        .Reset        (rst),
        .ReadRegister (rd_reg),
        .ReadEnable   (rd_en),
        .WriteRegister(wr_reg),
        .WriteData    (wr_data),
        .RegWrite     (reg_write),
        .ReadData     (rd_data),
        .ReadValid    (rd_valid),
        .Ready        (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_valid[i] === 1'b1) begin
                if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd%0d_unexpected_valid: got data %h with no read pending", i, rd_data[i*32 +: 32]);
                end else begin
                    check($sformatf("rd%0d_data", i), rd_data[i*32 +: 32],
                          i == 0 ? exp_q0.pop_front() : exp_q1.pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        rd_en     = en;
        rd_reg    = {a1, a0};
        reg_write = we;
        wr_reg    = wa;
        wr_data   = wd;
        if (en[0]) exp_q0.push_back(e0);
        if (en[1]) exp_q1.push_back(e1);
        @(posedge clk) #1;
    endtask

    task automatic idle();
        cyc(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(posedge clk) #1;
            n++;
        end
        check(name, 32'(n), 32'd32);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rd_en = '0; rd_reg = '0; reg_write = 1'b0; wr_reg = '0; wr_data = '0;
        @(posedge clk) #1;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_valid", 32'(rd_valid), 32'd0);
        check("reset_data0", rd_data[31:0], 32'd0);
        check("reset_data1", rd_data[63:32], 32'd0);
        // Accesses during clear must be ignored: no valid, no write to reg3.
        rst = 1'b0; rd_en = 2'b11; rd_reg = {5'd3, 5'd3};
        reg_write = 1'b1; wr_reg = 5'd3; wr_data = 32'h5555_5555;
        wait_ready("clear_edges");
        idle();
        for (int i = 1; i < 32; i++)
            cyc(2'b11, 5'(i), 5'(32 - i), 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc(2'b00, 5'd0, 5'd0, 0, 0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        cyc(2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 0, 1'b0, 5'd0, 0);
        cyc(2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'h1234);
        cyc(2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 0);
        cyc(2'b00, 5'd0, 5'd0, 0, 0, 1'b1, 5'd7, 32'h4);
`ifdef REGFILE_BYPASS_EN
        cyc(2'b10, 5'd0, 5'd7, 0, 32'hA5A5_A5A5, 1'b1, 5'd7, 32'hA5A5_A5A5);
`else
        cyc(2'b10, 5'd0, 5'd7, 0, 32'h0000_0004, 1'b1, 5'd7, 32'hA5A5_A5A5);
`endif
        cyc(2'b11, 5'd7, 5'd5, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0, 5'd0, 0);
        idle();
        check("hold_data1", rd_data[63:32], 32'hDEAD_BEEF);
        check("hold_valid1", 32'(rd_valid[1]), 32'd0);
        cyc(2'b11, 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 5'd0, 0);
        idle();
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        check("rereset_ready", 32'(ready), 32'd0);
        rst = 1'b0; reg_write = 1'b1; wr_reg = 5'd9; wr_data = 32'h99;
        wait_ready("reclear_edges");
        idle();
        cyc(2'b11, 5'd5, 5'd9, 32'h0, 32'h0, 1'b0, 5'd0, 0);
        cyc(2'b11, 5'd3, 5'd7, 32'h0, 32'h0, 1'b0, 5'd0, 0);
        idle();
        idle();
        check("pending_rd0", 32'(exp_q0.size()), 32'd0);
        check("pending_rd1", 32'(exp_q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
